// File: rtl/seg_scan_ctrl_pkg.sv
// Shared encodings for the 7-segment scan controller: FSM states and
// the idle patterns driven onto the anode and segment lines.
package seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Wide enough for any sensible digit count; the top slices off DIGITS bits.
    localparam logic [31:0] AN_OFF    = '1;
    localparam logic [6:0]  SEG_BLANK = 7'b0;

endpackage

// File: rtl/seg_scan_ctrl_bcd7.sv
// Hex nibble to 7-segment decoder; output is {g,f,e,d,c,b,a}, active-high.
module seg_scan_ctrl_bcd7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0000000;
        case (nibble)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with dead-time gaps,
// double-buffered display value and optional leading-zero blanking.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 500,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_tick
);
    import seg_scan_ctrl_pkg::*;

    localparam int                IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIGITS-1:0] AN_ALL_OFF = AN_OFF[DIGITS-1:0];

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0]  disp_val_q, disp_val_d;
    logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;
    logic                 pending_q, pending_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic                 frame_tick_q, frame_tick_d;

    logic                 commit_slot;
    logic                 lead_zero;
    logic [DIGITS-1:0]    blank_vec;
    logic [3:0]           nibble;
    logic [6:0]           seg_dec;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        frame_tick_d = 1'b0;
        commit_slot  = 1'b0;
        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d     = ST_SHOW;
                    cnt_d       = '0;
                    commit_slot = (idx_q == '0);
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d      = ST_GAP;
                    cnt_d        = '0;
                    idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    frame_tick_d = (idx_q == IDX_LAST);
                end
            end
            default: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
        endcase
    end

    // A load landing on the commit edge goes straight to the display so the
    // new frame already shows it.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;
        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
        end
        if (commit_slot) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
                pending_d  = 1'b0;
            end else if (pending_q) begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
                pending_d  = 1'b0;
            end
        end
    end

    always_comb begin
        lead_zero = 1'b1;
        blank_vec = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead_zero    = lead_zero & (disp_val_d[4*i +: 4] == 4'h0);
            blank_vec[i] = blank_lz & lead_zero;
        end
    end

    assign nibble = disp_val_d[4*idx_d +: 4];

    seg_scan_ctrl_bcd7 u_bcd7 (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Outputs follow the next state so anodes switch on the same edge as the FSM.
    always_comb begin
        an_d  = AN_ALL_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        if (state_d == ST_SHOW && !blank_vec[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = seg_dec;
            dp_d        = disp_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_GAP;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_ALL_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Frame-level bench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=4, GAP_CYC=2):
// each table row describes one 24-cycle frame, its loads and expected digits.
module tb_seg_scan_ctrl;

    typedef struct packed {
        logic             bl;
        logic [5:0]       ld_j;
        logic [15:0]      ld_val;
        logic [3:0]       ld_dp;
        logic [5:0]       ld2_j;
        logic [15:0]      ld2_val;
        logic [3:0]       ld2_dp;
        logic [3:0][6:0]  seg;
        logic [3:0]       dpv;
        logic [3:0]       blk;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    logic [12:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    frame_t      frames[7];
    frame_t      f_rst;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS   (4),
        .SCAN_DIV (4),
        .GAP_CYC  (2),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Expected {an, seg, dp, frame_tick} after the edge at frame phase ph.
    function automatic logic [12:0] exp_word(input int ph, input frame_t f, input logic tick);
        int         d;
        logic [3:0] an_e;
        an_e = 4'hF;
        if ((ph % 6) < 2) return {4'hF, 7'h00, 1'b0, tick};
        d = ph / 6;
        if (f.blk[d]) return {4'hF, 7'h00, 1'b0, tick};
        an_e[d] = 1'b0;
        return {an_e, f.seg[d], f.dpv[d], tick};
    endfunction

    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d,
                        input logic bl, input logic [12:0] e, input string name);
        logic [12:0] got;
        logic [12:0] want;
        load     = ld;
        value    = v;
        dp_in    = d;
        blank_lz = bl;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        got  = {an, seg, dp, frame_tick};
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                     name, got[12:9], got[8:2], got[1], got[0],
                     want[12:9], want[8:2], want[1], want[0]);
        end
    endtask

    task automatic run_frame(input frame_t f, input int last_j, input string tag);
        logic        ld;
        logic [15:0] v;
        logic [3:0]  d;
        for (int j = 1; j <= last_j; j++) begin
            ld = (j == int'(f.ld_j)) || (j == int'(f.ld2_j));
            v  = (j == int'(f.ld2_j)) ? f.ld2_val : f.ld_val;
            d  = (j == int'(f.ld2_j)) ? f.ld2_dp  : f.ld_dp;
            step(ld, v, d, f.bl, exp_word(j % 24, f, j == 24), $sformatf("%s_j%0d", tag, j));
        end
    endtask

    initial begin
        // Power-on contents, then mid-frame load of 12AF.
        frames[0] = '{bl: 1'b0, ld_j: 6'd10, ld_val: 16'h12AF, ld_dp: 4'b0100,
                      ld2_j: 6'd0, ld2_val: 16'h0, ld2_dp: 4'h0,
                      seg: {7'h3F, 7'h3F, 7'h3F, 7'h3F}, dpv: 4'b0000, blk: 4'b0000};
        frames[1] = '{bl: 1'b0, ld_j: 6'd12, ld_val: 16'h0030, ld_dp: 4'b0000,
                      ld2_j: 6'd0, ld2_val: 16'h0, ld2_dp: 4'h0,
                      seg: {7'h06, 7'h5B, 7'h77, 7'h71}, dpv: 4'b0100, blk: 4'b0000};
        frames[2] = '{bl: 1'b1, ld_j: 6'd5, ld_val: 16'h1111, ld_dp: 4'b0000,
                      ld2_j: 6'd15, ld2_val: 16'h2222, ld2_dp: 4'b0000,
                      seg: {7'h00, 7'h00, 7'h4F, 7'h3F}, dpv: 4'b0000, blk: 4'b1100};
        frames[3] = '{bl: 1'b1, ld_j: 6'd20, ld_val: 16'h4444, ld_dp: 4'b0000,
                      ld2_j: 6'd0, ld2_val: 16'h0, ld2_dp: 4'h0,
                      seg: {7'h5B, 7'h5B, 7'h5B, 7'h5B}, dpv: 4'b0000, blk: 4'b0000};
        // j=2 is the commit edge: 8888 must appear in this very frame.
        frames[4] = '{bl: 1'b1, ld_j: 6'd2, ld_val: 16'h8888, ld_dp: 4'b0000,
                      ld2_j: 6'd10, ld2_val: 16'h0000, ld2_dp: 4'b1000,
                      seg: {7'h7F, 7'h7F, 7'h7F, 7'h7F}, dpv: 4'b0000, blk: 4'b0000};
        frames[5] = '{bl: 1'b1, ld_j: 6'd0, ld_val: 16'h0, ld_dp: 4'h0,
                      ld2_j: 6'd0, ld2_val: 16'h0, ld2_dp: 4'h0,
                      seg: {7'h00, 7'h00, 7'h00, 7'h3F}, dpv: 4'b0000, blk: 4'b1110};
        frames[6] = '{bl: 1'b0, ld_j: 6'd0, ld_val: 16'h0, ld_dp: 4'h0,
                      ld2_j: 6'd0, ld2_val: 16'h0, ld2_dp: 4'h0,
                      seg: {7'h3F, 7'h3F, 7'h3F, 7'h3F}, dpv: 4'b1000, blk: 4'b0000};
        f_rst     = '{bl: 1'b0, ld_j: 6'd0, ld_val: 16'h0, ld_dp: 4'h0,
                      ld2_j: 6'd0, ld2_val: 16'h0, ld2_dp: 4'h0,
                      seg: {7'h3F, 7'h3F, 7'h3F, 7'h3F}, dpv: 4'b0000, blk: 4'b0000};

        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an",   32'(an),         32'hF);
        check("rst_seg",  32'(seg),        32'h0);
        check("rst_dp",   32'(dp),         32'h0);
        check("rst_tick", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;

        for (int f = 0; f < 7; f++) run_frame(frames[f], 24, $sformatf("f%0d", f));

        // Stop inside digit 2's lit slot and pull reset between clock edges.
        run_frame(frames[6], 15, "f7");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an",   32'(an),         32'hF);
        check("async_rst_seg",  32'(seg),        32'h0);
        check("async_rst_dp",   32'(dp),         32'h0);
        check("async_rst_tick", 32'(frame_tick), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(f_rst, 24, "f8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display on the FPGA board. Holds a hex value supplied by the CPU-side logic, steps through the digits with a dead-time gap between them to prevent ghosting, and drives each nibble through the existing BCD7 hex-to-segment decoder. New values are double-buffered and committed only at frame start, so no frame ever shows a mix of old and new digits.

Parameters:
DIGITS, 4, number of digits scanned (index 0 = least significant nibble)
SCAN_DIV, 50000, clk cycles each digit is lit (>=2)
GAP_CYC, 500, clk cycles all anodes are off between digits (>=1)
CNT_W, 16, width of the dwell counter; must hold max(SCAN_DIV, GAP_CYC)-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe; captures value/dp_in into shadow
value  in  4*DIGITS  hex value to display
dp_in  in  DIGITS  decimal-point enables, bit i -> digit i
blank_lz  in  1  leading-zero blanking enable (sampled live)
an  out  DIGITS  anode selects, active-low, registered
seg  out  7  segment pattern {g..a}, active-high, registered
dp  out  1  decimal point, active-high, registered
frame_tick  out  1  one-cycle pulse at end of each full scan frame

Behaviour:
- Reset (async, rst_n=0): an=all 1s, seg=0, dp=0, frame_tick=0, state=GAP, idx=0, cnt=0, shadow=0, disp=0, dp regs=0, pending=0. Takes effect immediately, including mid-SHOW.
- FSM states GAP, SHOW; cnt counts dwell cycles in the current state and clears on every transition.
- GAP -> SHOW when cnt==GAP_CYC-1. SHOW -> GAP when cnt==SCAN_DIV-1; idx <= (idx==DIGITS-1) ? 0 : idx+1.
- frame_tick=1 for exactly the cycle after the SHOW->GAP transition with idx==DIGITS-1; period = DIGITS*(SCAN_DIV+GAP_CYC).
- load: shadow <= {value, dp_in}, pending <= 1. Multiple loads before commit: last wins.
- Commit: on the GAP->SHOW transition with idx==0 and pending=1: disp <= shadow, pending <= 0. If load coincides with a commit cycle, the incoming value/dp_in is committed directly (bypass) and pending stays 0.
- Output registers load from next-state logic, so outputs change in the same edge as the state change:
  - GAP: an=all 1s, seg=0, dp=0.
  - SHOW, digit idx not blanked: an[idx]=0, others 1; seg=BCD7(disp nibble idx); dp=disp_dp[idx].
  - SHOW, digit blanked: an=all 1s, seg=0, dp=0; dwell time unchanged.
- Blanking: digit i (i>=1) is blanked iff blank_lz=1 and nibbles DIGITS-1 down to i of disp are all zero. Digit 0 is never blanked. The dp bit does not prevent blanking.
- Width rules: cnt is CNT_W bits and compares against parameter-1, with no overflow in legal configurations. idx is $clog2(DIGITS) bits and wraps explicitly, never by overflow.

Decomposition:
- Shared package/header: state encodings (ST_GAP, ST_SHOW), AN_OFF (all ones), SEG_BLANK (7'b0).
- One sub-module: the existing BCD7 decoder, instantiated once on the muxed nibble disp[4*idx +: 4]. Its output feeds the seg register.
- FSM, counters, buffers and blanking logic stay in seg_scan_ctrl.

Test Plan:
- All tests use DIGITS=4, SCAN_DIV=4, GAP_CYC=2.
- Reset release, no load -> an=1111 for 2 cycles, then an=1110 with seg=7'b0111111 for 4 cycles. During digits 1..3 with blank_lz=0, seg=7'b0111111 on each.
- load value=16'h12AF, dp_in=4'b0100 mid-frame -> current frame unchanged. Next frame: digit0 seg=7'b1110001, digit1 7'b1110111, digit2 7'b1011011 with dp=1, digit3 7'b0000110.
- blank_lz=1, value=16'h0030 -> digit3 and digit2 keep an=1111, seg=0 for their 4-cycle slots. Digit1 seg=7'b1001111, digit0 seg=7'b0111111.
- load 16'h1111 then load 16'h2222 in the same frame -> next frame shows only 2 (7'b1011011) on all digits; 1 is never displayed. A load in the exact commit cycle is shown in that frame.
- Free run -> frame_tick pulses one cycle wide, every 24 cycles. an never has more than one 0 bit, and every anode change passes through 2 cycles of 1111.
- rst_n=0 asynchronously mid-SHOW on digit 2 -> an=1111, seg=0 before the next clk edge. After release, the scan restarts at digit 0 showing 0.
